// File: rtl/regfile_writeback_unit.sv
// Write-back end of the register-file write port.
// Merges LSU and EXU results into a small in-order FIFO, retires one entry per
// cycle into the register file, and keeps per-register pending-write counters
// so decode can stall sources whose writes are still in flight.
module regfile_writeback_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         exu_valid,
    output logic                         exu_ready,
    input  logic [4:0]                   exu_rd,
    input  logic [DATA_WIDTH-1:0]        exu_data,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [4:0]                   lsu_rd,
    input  logic [DATA_WIDTH-1:0]        lsu_data,
    input  logic                         iss_alloc,
    input  logic [4:0]                   iss_rd,
    input  logic [4:0]                   chk_rs1,
    input  logic [4:0]                   chk_rs2,
    output logic                         rs1_busy,
    output logic                         rs2_busy,
    output logic                         rf_we,
    output logic [4:0]                   rf_rd,
    output logic [DATA_WIDTH-1:0]        rf_wdata,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic                         sb_err
);

    localparam int IDX_W = $clog2(ADDR_WIDTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]            mem_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      free;
    logic [CNT_W-1:0]      n_push;
    logic [4:0]            last_rd;
    logic [DATA_WIDTH-1:0] last_data;
    logic                  lsu_push, exu_push, pop;

    logic [1:0]            pend [ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] inc_v, dec_v;
    logic                  err_set;
    logic                  err_q;

    // Readiness depends only on occupancy; EXU needs two free slots so an
    // LSU result arriving in the same cycle always finds room ahead of it.
    assign free      = CNT_W'(DEPTH) - count;
    assign lsu_ready = !rst && (free >= CNT_W'(1));
    assign exu_ready = !rst && (free >= CNT_W'(2));

    // Results to x0 complete the handshake but never occupy a slot.
    assign lsu_push = lsu_valid && lsu_ready && (lsu_rd[IDX_W-1:0] != '0);
    assign exu_push = exu_valid && exu_ready && (exu_rd[IDX_W-1:0] != '0);
    assign n_push   = CNT_W'(lsu_push) + CNT_W'(exu_push);
    assign pop      = !rst && (count != '0);

    // The head is read straight out of registered storage; when empty the
    // last retired entry is shown so the write port holds its value.
    assign rf_we      = pop;
    assign rf_rd      = rst ? '0 : ((count != '0) ? mem_rd[rd_ptr]   : last_rd);
    assign rf_wdata   = rst ? '0 : ((count != '0) ? mem_data[rd_ptr] : last_data);
    assign fifo_count = rst ? '0 : count;
    assign sb_err     = err_q;

    // FIFO storage: LSU takes the older slot when both push together.
    always_ff @(posedge clk) begin
        if (lsu_push) begin
            mem_rd[wr_ptr]   <= lsu_rd;
            mem_data[wr_ptr] <= lsu_data;
        end
        if (exu_push) begin
            mem_rd[wr_ptr + PTR_W'(lsu_push)]   <= exu_rd;
            mem_data[wr_ptr + PTR_W'(lsu_push)] <= exu_data;
        end
    end

    // FIFO pointers, occupancy and last-retired hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_rd   <= '0;
            last_data <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            count  <= count + n_push - CNT_W'(pop);
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_rd   <= mem_rd[rd_ptr];
                last_data <= mem_data[rd_ptr];
            end
        end
    end

    // Per-register increment/decrement requests and protocol error detection.
    always_comb begin
        inc_v   = '0;
        dec_v   = '0;
        err_set = 1'b0;
        for (int r = 1; r < ADDR_WIDTH; r++) begin
            inc_v[r] = iss_alloc && (iss_rd[IDX_W-1:0] == IDX_W'(r));
            dec_v[r] = pop && (rf_rd[IDX_W-1:0] == IDX_W'(r));
            if (inc_v[r] && !dec_v[r] && (pend[r] == 2'd3))
                err_set = 1'b1;
            if (dec_v[r] && !inc_v[r] && (pend[r] == 2'd0))
                err_set = 1'b1;
        end
    end

    // Pending-write counters saturate at both ends; the error flag is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ADDR_WIDTH; r++)
                pend[r] <= 2'd0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < ADDR_WIDTH; r++) begin
                if (inc_v[r] && !dec_v[r] && (pend[r] != 2'd3))
                    pend[r] <= pend[r] + 2'd1;
                else if (dec_v[r] && !inc_v[r] && (pend[r] != 2'd0))
                    pend[r] <= pend[r] - 2'd1;
            end
            err_q <= err_q | err_set;
        end
    end

    // x0 never counts as busy because its counter is never touched.
    assign rs1_busy = !rst && (pend[chk_rs1[IDX_W-1:0]] != 2'd0);
    assign rs2_busy = !rst && (pend[chk_rs2[IDX_W-1:0]] != 2'd0);

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Self-checking bench for regfile_writeback_unit with a queue-based reference.
module tb_regfile_writeback_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        exu_valid, lsu_valid, iss_alloc;
    logic        exu_ready, lsu_ready;
    logic [4:0]  exu_rd, lsu_rd, iss_rd, chk_rs1, chk_rs2;
    logic [31:0] exu_data, lsu_data;
    logic        rs1_busy, rs2_busy, rf_we, sb_err;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          sb[16];
    bit          m_err;
    logic [4:0]  m_last_rd;
    logic [31:0] m_last_data;

    regfile_writeback_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_alloc(iss_alloc), .iss_rd(iss_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .fifo_count(fifo_count), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_busy(logic [4:0] r);
        int i = int'(r) % 16;
        return (i != 0) && (sb[i] != 0);
    endfunction

    function automatic logic [4:0] m_rd();
        return (q.size() != 0) ? q[0].rd : m_last_rd;
    endfunction

    function automatic logic [31:0] m_data();
        return (q.size() != 0) ? q[0].data : m_last_data;
    endfunction

    // Advance the reference by one clock using the inputs currently applied.
    task automatic model_step();
        int   free;
        bit   la, ea, pop, inc, dec;
        ent_t h;
        if (rst) begin
            q.delete();
            foreach (sb[i]) sb[i] = 0;
            m_err = 0;
            m_last_rd = '0;
            m_last_data = '0;
            return;
        end
        free = DEPTH - q.size();
        la = lsu_valid && (free >= 1);
        ea = exu_valid && (free >= 2);
        pop = (q.size() != 0);
        h = '{rd: 5'd0, data: 32'd0};
        if (pop) begin
            h = q.pop_front();
            m_last_rd = h.rd;
            m_last_data = h.data;
        end
        for (int i = 1; i < 16; i++) begin
            inc = iss_alloc && (int'(iss_rd) % 16 == i);
            dec = pop && (int'(h.rd) % 16 == i);
            if (inc && !dec) begin
                if (sb[i] == 3) m_err = 1; else sb[i]++;
            end else if (dec && !inc) begin
                if (sb[i] == 0) m_err = 1; else sb[i]--;
            end
        end
        if (la && (int'(lsu_rd) % 16 != 0)) q.push_back('{rd: lsu_rd, data: lsu_data});
        if (ea && (int'(exu_rd) % 16 != 0)) q.push_back('{rd: exu_rd, data: exu_data});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        exu_valid = 0; lsu_valid = 0; iss_alloc = 0;
        exu_rd = 0; lsu_rd = 0; iss_rd = 0;
        exu_data = 0; lsu_data = 0;
        chk_rs1 = 0; chk_rs2 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        #1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        checks++;
        if (lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_lsu_ready got %0b want 1", lsu_ready); end
        checks++;
        if (exu_ready !== 1'b1) begin errors++; $display("FAIL reset_exu_ready got %0b want 1", exu_ready); end
        checks++;
        if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got %0b want 0", sb_err); end
        checks++;
        if (rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_rf_out got rd=%0d data=%h want 0/0", rf_rd, rf_wdata);
        end
        checks++;
    endtask

    task automatic test_single();
        idle_inputs();
        iss_alloc = 1; iss_rd = 5'd5; chk_rs1 = 5'd5;
        #1; tick();
        iss_alloc = 0;
        exu_valid = 1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
        #1;
        if (rs1_busy !== 1'b1) begin errors++; $display("FAIL single_busy_pre got %0b want 1", rs1_busy); end
        checks++;
        if (exu_ready !== 1'b1) begin errors++; $display("FAIL single_exu_ready got %0b want 1", exu_ready); end
        checks++;
        tick();
        exu_valid = 0;
        #1;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_write got we=%0b rd=%0d data=%h want 1/5/deadbeef", rf_we, rf_rd, rf_wdata);
        end
        checks++;
        if (rs1_busy !== 1'b1) begin errors++; $display("FAIL single_busy_during got %0b want 1", rs1_busy); end
        checks++;
        tick();
        if (rf_we !== 1'b0 || rs1_busy !== 1'b0) begin
            errors++; $display("FAIL single_after got we=%0b busy=%0b want 0/0", rf_we, rs1_busy);
        end
        checks++;
        if (rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_hold got rd=%0d data=%h want 5/deadbeef", rf_rd, rf_wdata);
        end
        checks++;
    endtask

    task automatic test_dual();
        idle_inputs();
        lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h11;
        exu_valid = 1; exu_rd = 5'd4; exu_data = 32'h22;
        #1;
        if (lsu_ready !== 1'b1 || exu_ready !== 1'b1) begin
            errors++; $display("FAIL dual_ready got lsu=%0b exu=%0b want 1/1", lsu_ready, exu_ready);
        end
        checks++;
        tick();
        idle_inputs();
        #1;
        if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h11 || fifo_count !== 3'd2) begin
            errors++; $display("FAIL dual_first got we=%0b rd=%0d data=%h cnt=%0d want 1/3/11/2", rf_we, rf_rd, rf_wdata, fifo_count);
        end
        checks++;
        tick();
        if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'h22) begin
            errors++; $display("FAIL dual_second got we=%0b rd=%0d data=%h want 1/4/22", rf_we, rf_rd, rf_wdata);
        end
        checks++;
        tick();
        if (rf_we !== 1'b0) begin errors++; $display("FAIL dual_drained got %0b want 0", rf_we); end
        checks++;
    endtask

    task automatic test_back_to_back();
        int max_cnt = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            lsu_valid = 1; lsu_rd = 5'($urandom_range(1, 15)); lsu_data = $urandom;
            exu_valid = 1; exu_rd = 5'($urandom_range(1, 15)); exu_data = $urandom;
            #1;
            if (fifo_count !== 3'(q.size()) || lsu_ready !== (DEPTH - q.size() >= 1) ||
                exu_ready !== (DEPTH - q.size() >= 2)) begin
                errors++; $display("FAIL b2b_state c=%0d got cnt=%0d lr=%0b er=%0b want cnt=%0d", c, fifo_count, lsu_ready, exu_ready, q.size());
            end
            checks++;
            if (rf_we !== (q.size() != 0) || rf_rd !== m_rd() || rf_wdata !== m_data()) begin
                errors++; $display("FAIL b2b_order c=%0d got we=%0b rd=%0d data=%h want rd=%0d data=%h", c, rf_we, rf_rd, rf_wdata, m_rd(), m_data());
            end
            checks++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            tick();
        end
        if (max_cnt != DEPTH - 1) begin errors++; $display("FAIL b2b_peak got %0d want %0d", max_cnt, DEPTH - 1); end
        checks++;
        idle_inputs();
        #1;
        while (q.size() != 0) begin
            if (rf_we !== 1'b1 || rf_rd !== m_rd() || rf_wdata !== m_data()) begin
                errors++; $display("FAIL b2b_drain got rd=%0d data=%h want rd=%0d data=%h", rf_rd, rf_wdata, m_rd(), m_data());
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_x0();
        do_reset();
        exu_valid = 1; exu_rd = 5'd0; exu_data = 32'hFFFF;
        #1;
        if (exu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %0b want 1", exu_ready); end
        checks++;
        tick();
        idle_inputs();
        #1;
        if (fifo_count !== 3'd0 || rf_we !== 1'b0) begin
            errors++; $display("FAIL x0_dropped got cnt=%0d we=%0b want 0/0", fifo_count, rf_we);
        end
        checks++;
    endtask

    task automatic test_sb_overflow();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            iss_alloc = 1; iss_rd = 5'd7;
            #1; tick();
        end
        idle_inputs();
        chk_rs1 = 5'd7; chk_rs2 = 5'd0;
        #1;
        if (sb_err !== 1'b1) begin errors++; $display("FAIL sb_overflow_err got %0b want 1", sb_err); end
        checks++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
            errors++; $display("FAIL sb_overflow_busy got rs1=%0b rs2=%0b want 1/0", rs1_busy, rs2_busy);
        end
        checks++;
    endtask

    task automatic test_reset_queued();
        idle_inputs();
        iss_alloc = 1; iss_rd = 5'd9;
        lsu_valid = 1; lsu_rd = 5'd1; lsu_data = 32'hA1;
        exu_valid = 1; exu_rd = 5'd2; exu_data = 32'hA2;
        #1; tick();
        lsu_rd = 5'd3; exu_rd = 5'd4;
        #1; tick();
        idle_inputs();
        chk_rs1 = 5'd9; chk_rs2 = 5'd7;
        #1;
        if (fifo_count !== 3'd3) begin errors++; $display("FAIL rstq_count_pre got %0d want 3", fifo_count); end
        checks++;
        do_reset();
        chk_rs1 = 5'd9; chk_rs2 = 5'd7;
        #1;
        if (fifo_count !== 3'd0 || rf_we !== 1'b0 || sb_err !== 1'b0) begin
            errors++; $display("FAIL rstq_state got cnt=%0d we=%0b err=%0b want 0/0/0", fifo_count, rf_we, sb_err);
        end
        checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            errors++; $display("FAIL rstq_busy got rs1=%0b rs2=%0b want 0/0", rs1_busy, rs2_busy);
        end
        checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            lsu_valid = ($urandom % 3) != 0; lsu_rd = 5'($urandom_range(0, 15)); lsu_data = $urandom;
            exu_valid = ($urandom % 2) != 0; exu_rd = 5'($urandom_range(0, 15)); exu_data = $urandom;
            iss_alloc = ($urandom % 3) == 0; iss_rd = 5'($urandom_range(0, 15));
            chk_rs1 = 5'($urandom_range(0, 15)); chk_rs2 = 5'($urandom_range(0, 15));
            #1;
            if (rf_we !== (q.size() != 0) || rf_rd !== m_rd() || rf_wdata !== m_data()) begin
                errors++; $display("FAIL rand_rf c=%0d got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h",
                                   c, rf_we, rf_rd, rf_wdata, q.size() != 0, m_rd(), m_data());
            end
            checks++;
            if (fifo_count !== 3'(q.size()) || lsu_ready !== (DEPTH - q.size() >= 1) ||
                exu_ready !== (DEPTH - q.size() >= 2)) begin
                errors++; $display("FAIL rand_fifo c=%0d got cnt=%0d lr=%0b er=%0b want cnt=%0d", c, fifo_count, lsu_ready, exu_ready, q.size());
            end
            checks++;
            if (rs1_busy !== m_busy(chk_rs1) || rs2_busy !== m_busy(chk_rs2) || sb_err !== m_err) begin
                errors++; $display("FAIL rand_sb c=%0d got b1=%0b b2=%0b err=%0b want %0b/%0b/%0b",
                                   c, rs1_busy, rs2_busy, sb_err, m_busy(chk_rs1), m_busy(chk_rs2), m_err);
            end
            checks++;
            tick();
            if (c == 150) begin
                rst = 1; idle_inputs(); #1; tick(); rst = 0;
            end
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_dual();
        test_back_to_back();
        test_x0();
        test_sb_overflow();
        test_reset_queued();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
